// File: rtl/cve2_obi_arbiter.sv
// Merges the core's instruction and data OBI master ports onto one shared memory port.
// Grants are zero-latency; an ID FIFO routes each response back to the port that issued it.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 instr_req_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_rvalid_o,
  input  logic [31:0]                          instr_addr_i,
  output logic [31:0]                          instr_rdata_o,
  output logic                                 instr_err_o,
  input  logic                                 data_req_i,
  output logic                                 data_gnt_o,
  output logic                                 data_rvalid_o,
  input  logic                                 data_we_i,
  input  logic [3:0]                           data_be_i,
  input  logic [31:0]                          data_addr_i,
  input  logic [31:0]                          data_wdata_i,
  output logic [31:0]                          data_rdata_o,
  output logic                                 data_err_o,
  output logic                                 mem_req_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  output logic                                 mem_we_o,
  output logic [3:0]                           mem_be_o,
  output logic [31:0]                          mem_addr_o,
  output logic [31:0]                          mem_wdata_o,
  input  logic [31:0]                          mem_rdata_i,
  input  logic                                 mem_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 resp_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxOutstanding - 1);

  // Source encoding: 0 = instruction port, 1 = data port.
  logic [MaxOutstanding-1:0] id_q;
  logic [PtrW-1:0]           wptr_q, rptr_q;
  logic [CntW-1:0]           cnt_q;
  logic                      lock_q, sel_q, rr_q, resp_err_q;

  logic full, empty, sel, sel_req, push, pop, head;

  // Arbitration and request path
  always_comb begin
    full  = (cnt_q == CntW'(MaxOutstanding));
    empty = (cnt_q == '0);
    if (lock_q) begin
      sel = sel_q;
    end else if (instr_req_i && data_req_i) begin
      sel = DataPriority ? 1'b1 : rr_q;
    end else begin
      sel = data_req_i;
    end
    sel_req   = sel ? data_req_i : instr_req_i;
    mem_req_o = rst_ni & sel_req & ~full;
    push      = mem_req_o & mem_gnt_i;
    pop       = mem_rvalid_i & ~empty;
    head      = id_q[rptr_q];
  end

  assign instr_gnt_o = push & ~sel;
  assign data_gnt_o  = push & sel;

  // Payload mux; zero whenever no request is presented
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      if (sel) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign outstanding_o  = cnt_q;
  assign resp_err_o     = resp_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      sel_q      <= 1'b0;
      rr_q       <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (push) begin
        id_q[wptr_q] <= sel;
        wptr_q       <= (wptr_q == PtrMax) ? '0 : wptr_q + PtrW'(1);
        rr_q         <= ~rr_q;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrMax) ? '0 : rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      // Hold the selected source until the shared port accepts it
      if (push) begin
        lock_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (mem_rvalid_i && empty) begin
        resp_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Bench for cve2_obi_arbiter: vector table, directed corner sequences and a randomized
// run of a priority instance and a round-robin instance against a queue-based model.
module tb_cve2_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b1, mgnt = 1'b0, mrv = 1'b0, merr = 1'b0;
  logic [31:0] iaddr = 32'h1000, daddr = 32'h100, dwdata = 32'hdead_beef, mrdata = 32'h0;
  logic [3:0]  dbe = 4'h3;

  logic [1:0]  igt, dgt, irv, drv, mreq, mwe, ierr, derr, rerr;
  logic [3:0]  mbe    [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic [31:0] irdata [2];
  logic [31:0] drdata [2];
  logic [1:0]  outst  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_gnt_o(igt[0]), .instr_rvalid_o(irv[0]), .instr_addr_i(iaddr),
    .instr_rdata_o(irdata[0]), .instr_err_o(ierr[0]),
    .data_req_i(dreq), .data_gnt_o(dgt[0]), .data_rvalid_o(drv[0]), .data_we_i(dwe),
    .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata), .data_rdata_o(drdata[0]),
    .data_err_o(derr[0]),
    .mem_req_o(mreq[0]), .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_we_o(mwe[0]),
    .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata),
    .mem_err_i(merr), .outstanding_o(outst[0]), .resp_err_o(rerr[0])
  );

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_gnt_o(igt[1]), .instr_rvalid_o(irv[1]), .instr_addr_i(iaddr),
    .instr_rdata_o(irdata[1]), .instr_err_o(ierr[1]),
    .data_req_i(dreq), .data_gnt_o(dgt[1]), .data_rvalid_o(drv[1]), .data_we_i(dwe),
    .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata), .data_rdata_o(drdata[1]),
    .data_err_o(derr[1]),
    .mem_req_o(mreq[1]), .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_we_o(mwe[1]),
    .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata),
    .mem_err_i(merr), .outstanding_o(outst[1]), .resp_err_o(rerr[1])
  );

  typedef struct {
    logic ir, dr, g, rv;
    logic igt, dgt, irv, drv, mreq;
    logic [1:0] outst;
    logic rerr;
    logic [31:0] addr;
    logic [3:0] be;
  } vec_t;

  typedef struct packed {
    logic igt, dgt, irv, drv, mreq, we;
    logic [3:0] be;
    logic [31:0] addr, wdata;
    logic [1:0] outst;
    logic rerr;
    logic [31:0] irdata, drdata;
    logic ierr, derr;
  } obs_t;

  // Reference model state per instance
  bit mq [2][$];
  bit m_lock [2];
  bit m_lsel [2];
  bit m_rr   [2];
  bit m_err  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv);
    @(negedge clk);
    ireq = ir; dreq = dr; mgnt = g; mrv = rv;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ireq = 1'b0; dreq = 1'b0; mgnt = 1'b0; mrv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of the model for instance m: predict, compare, then advance
  task automatic model_cycle(input int m, input bit dp, input int cyc);
    obs_t e, a;
    bit full, sel, sreq, pop, head;
    e = '0;
    e.irdata = mrdata; e.drdata = mrdata; e.ierr = merr; e.derr = merr;
    if (!rst_n) begin
      mq[m].delete();
      m_lock[m] = 1'b0; m_lsel[m] = 1'b0; m_rr[m] = 1'b0; m_err[m] = 1'b0;
    end else begin
      full = (mq[m].size() == 2);
      if (m_lock[m]) sel = m_lsel[m];
      else if (ireq && dreq) sel = dp ? 1'b1 : m_rr[m];
      else sel = dreq;
      sreq   = sel ? dreq : ireq;
      e.mreq = sreq && !full;
      e.igt  = e.mreq && mgnt && !sel;
      e.dgt  = e.mreq && mgnt && sel;
      pop    = mrv && (mq[m].size() != 0);
      head   = pop ? mq[m][0] : 1'b0;
      e.irv  = pop && !head;
      e.drv  = pop && head;
      e.outst = 2'(mq[m].size());
      e.rerr = m_err[m];
      if (e.mreq) begin
        e.be   = sel ? dbe : 4'hF;
        e.addr = sel ? daddr : iaddr;
        e.we   = sel ? dwe : 1'b0;
        e.wdata = sel ? dwdata : 32'h0;
      end
      if (mrv && mq[m].size() == 0) m_err[m] = 1'b1;
      if (pop) void'(mq[m].pop_front());
      if (e.mreq && mgnt) begin
        mq[m].push_back(sel);
        m_lock[m] = 1'b0;
        m_rr[m] = !m_rr[m];
      end else if (e.mreq) begin
        m_lock[m] = 1'b1;
        m_lsel[m] = sel;
      end
    end
    a = {igt[m], dgt[m], irv[m], drv[m], mreq[m], mwe[m], mbe[m], maddr[m], mwdata[m],
         outst[m], rerr[m], irdata[m], drdata[m], ierr[m], derr[m]};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL rand inst%0d cyc%0d: got %h want %h", m, cyc, a, e);
    end
  endtask

  initial begin
    vec_t tbl [18];
    //          ir dr g rv  igt dgt irv drv mreq outst rerr addr        be
    tbl[0]  = '{1, 0, 1, 0,  1, 0, 0, 0, 1,  2'd0, 0, 32'h1000, 4'hF};
    tbl[1]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0,  2'd1, 0, 32'h0,    4'h0};
    tbl[2]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  2'd0, 0, 32'h0,    4'h0};
    tbl[3]  = '{1, 1, 1, 0,  0, 1, 0, 0, 1,  2'd0, 0, 32'h100,  4'h3};
    tbl[4]  = '{1, 0, 1, 0,  1, 0, 0, 0, 1,  2'd1, 0, 32'h1000, 4'hF};
    tbl[5]  = '{0, 0, 0, 1,  0, 0, 0, 1, 0,  2'd2, 0, 32'h0,    4'h0};
    tbl[6]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0,  2'd1, 0, 32'h0,    4'h0};
    tbl[7]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  2'd0, 0, 32'h0,    4'h0};
    tbl[8]  = '{1, 0, 1, 0,  1, 0, 0, 0, 1,  2'd0, 0, 32'h1000, 4'hF};
    tbl[9]  = '{1, 0, 1, 0,  1, 0, 0, 0, 1,  2'd1, 0, 32'h1000, 4'hF};
    tbl[10] = '{1, 0, 1, 0,  0, 0, 0, 0, 0,  2'd2, 0, 32'h0,    4'h0};
    tbl[11] = '{1, 0, 1, 1,  0, 0, 1, 0, 0,  2'd2, 0, 32'h0,    4'h0};
    tbl[12] = '{1, 0, 1, 0,  1, 0, 0, 0, 1,  2'd1, 0, 32'h1000, 4'hF};
    tbl[13] = '{0, 0, 0, 1,  0, 0, 1, 0, 0,  2'd2, 0, 32'h0,    4'h0};
    tbl[14] = '{0, 0, 0, 1,  0, 0, 1, 0, 0,  2'd1, 0, 32'h0,    4'h0};
    tbl[15] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  2'd0, 0, 32'h0,    4'h0};
    tbl[16] = '{0, 0, 0, 1,  0, 0, 0, 0, 0,  2'd0, 0, 32'h0,    4'h0};
    tbl[17] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  2'd0, 1, 32'h0,    4'h0};

    // Outputs quiet while reset is held, even with requests and grant asserted
    @(negedge clk);
    ireq = 1'b1; dreq = 1'b1; mgnt = 1'b1; mrv = 1'b1;
    #2;
    chk("rst mem_req", 32'(mreq[0]), 32'h0);
    chk("rst gnt", 32'({igt[0], dgt[0]}), 32'h0);
    chk("rst rvalid", 32'({irv[0], drv[0]}), 32'h0);
    chk("rst outst", 32'(outst[0]), 32'h0);
    chk("rst resp_err", 32'(rerr[0]), 32'h0);
    do_reset();

    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].ir, tbl[k].dr, tbl[k].g, tbl[k].rv);
      chk($sformatf("row%0d igt", k),  32'(igt[0]),   32'(tbl[k].igt));
      chk($sformatf("row%0d dgt", k),  32'(dgt[0]),   32'(tbl[k].dgt));
      chk($sformatf("row%0d irv", k),  32'(irv[0]),   32'(tbl[k].irv));
      chk($sformatf("row%0d drv", k),  32'(drv[0]),   32'(tbl[k].drv));
      chk($sformatf("row%0d mreq", k), 32'(mreq[0]),  32'(tbl[k].mreq));
      chk($sformatf("row%0d outst", k), 32'(outst[0]), 32'(tbl[k].outst));
      chk($sformatf("row%0d rerr", k), 32'(rerr[0]),  32'(tbl[k].rerr));
      chk($sformatf("row%0d addr", k), maddr[0],      tbl[k].addr);
      chk($sformatf("row%0d be", k),   32'(mbe[0]),   32'(tbl[k].be));
    end

    // Sticky error clears only on reset
    do_reset();
    #2;
    chk("err cleared", 32'(rerr[0]), 32'h0);

    // Stalled instruction request keeps its payload despite a data request arriving
    drive(1, 0, 0, 0);
    chk("lock c0 addr", maddr[0], 32'h1000);
    drive(1, 1, 0, 0);
    chk("lock c1 addr", maddr[0], 32'h1000);
    chk("lock c1 be", 32'(mbe[0]), 32'hF);
    drive(1, 1, 0, 0);
    chk("lock c2 addr", maddr[0], 32'h1000);
    drive(1, 1, 1, 0);
    chk("lock c3 igt", 32'(igt[0]), 32'h1);
    chk("lock c3 dgt", 32'(dgt[0]), 32'h0);
    drive(0, 1, 1, 1);
    chk("lock c4 dgt", 32'(dgt[0]), 32'h1);
    chk("lock c4 irv", 32'(irv[0]), 32'h1);
    chk("lock c4 addr", maddr[0], 32'h100);
    chk("lock c4 we", 32'(mwe[0]), 32'h1);
    drive(0, 0, 0, 1);
    chk("lock c5 drv", 32'(drv[0]), 32'h1);
    drive(0, 0, 0, 0);
    chk("lock c6 outst", 32'(outst[0]), 32'h0);

    // Round-robin instance alternates I,D,I,D with responses in grant order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, i > 0);
      chk($sformatf("rr%0d igt", i), 32'(igt[1]), 32'(i % 2 == 0));
      chk($sformatf("rr%0d dgt", i), 32'(dgt[1]), 32'(i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("rr%0d irv", i), 32'(irv[1]), 32'((i - 1) % 2 == 0));
        chk($sformatf("rr%0d drv", i), 32'(drv[1]), 32'((i - 1) % 2 == 1));
        chk($sformatf("rr%0d outst", i), 32'(outst[1]), 32'h1);
      end
    end

    // Randomized run of both instances against the model
    do_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_lock[m] = 1'b0; m_lsel[m] = 1'b0; m_rr[m] = 1'b0; m_err[m] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 299) != 0);
      ireq   = ($urandom_range(0, 9) < 6);
      dreq   = ($urandom_range(0, 9) < 6);
      mgnt   = ($urandom_range(0, 1) == 1);
      iaddr  = $urandom;
      daddr  = $urandom;
      dwdata = $urandom;
      dbe    = 4'($urandom);
      dwe    = 1'($urandom);
      mrdata = $urandom;
      merr   = ($urandom_range(0, 9) == 0);
      mrv    = (mq[0].size() != 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      #2;
      model_cycle(0, 1'b1, c);
      model_cycle(1, 1'b0, c);
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
